// File: rtl/uart_rx_receiver.sv
// uart_rx_receiver: 8N1 serial receiver with mid-bit sampling,
// a valid/ack hold register, framing-error and overrun pulses.
module uart_rx_receiver #(
  parameter int CLOCK_SPEED = 50000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] dataOut,
  output logic       valid,
  input  logic       ack,
  output logic       frameError,
  output logic       overrun
);

  localparam logic [31:0] BIT_TICKS  = 32'(CLOCK_SPEED / BAUD_RATE);
  localparam logic [31:0] HALF_TICKS = BIT_TICKS / 32'd2;

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } state_t;

  state_t      state, state_d;
  logic        sync1, rxs;
  logic [31:0] cnt, target;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tick;

  always_comb begin
    state_d = state;
    target  = '0;
    tick    = 1'b0;
    unique case (state)
      IDLE: if (!rxs) state_d = START;
      START: begin
        target = HALF_TICKS - 32'd1;
        tick   = (cnt == target);
        if (tick) state_d = rxs ? IDLE : DATA;
      end
      DATA: begin
        target = BIT_TICKS - 32'd1;
        tick   = (cnt == target);
        if (tick && bit_idx == 3'd7) state_d = STOP;
      end
      STOP: begin
        target = BIT_TICKS - 32'd1;
        tick   = (cnt == target);
        if (tick) state_d = rxs ? IDLE : BRK;
      end
      BRK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      dataOut    <= '0;
      valid      <= 1'b0;
      frameError <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync1      <= uart_rx;
      rxs        <= sync1;
      frameError <= 1'b0;
      overrun    <= 1'b0;
      if (valid && ack) valid <= 1'b0;
      // counter restarts on each state entry and on every data bit
      if (state_d != state || state == IDLE || state == BRK ||
          (state == DATA && tick))
        cnt <= '0;
      else
        cnt <= cnt + 32'd1;
      if (state == START && tick) bit_idx <= '0;
      if (state == DATA && tick) begin
        shreg[bit_idx] <= rxs;
        bit_idx        <= bit_idx + 3'd1;
      end
      if (state == STOP && tick) begin
        if (rxs) begin
          dataOut <= shreg;
          valid   <= 1'b1;
          overrun <= valid && !ack;
        end else begin
          frameError <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_receiver.sv
// tb_uart_rx_receiver: directed and random 8N1 frames checked
// against a frame-level model of the receiver's outputs.
module tb_uart_rx_receiver;

  localparam int BT = 16;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       ack     = 1'b0;
  logic [7:0] dataOut;
  logic       valid, frameError, overrun;

  uart_rx_receiver #(
    .CLOCK_SPEED(16),
    .BAUD_RATE  (1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .uart_rx   (uart_rx),
    .dataOut   (dataOut),
    .valid     (valid),
    .ack       (ack),
    .frameError(frameError),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   fe_seen = 0, ov_seen = 0;
  int   rise_cyc = -1, start_cyc = 0, lat = 0;
  logic valid_q = 1'b0;

  logic [7:0] m_data  = '0;
  logic       m_valid = 1'b0;
  int         m_fe = 0, m_ov = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (frameError) fe_seen <= fe_seen + 1;
    if (overrun) ov_seen <= ov_seen + 1;
    if (valid && !valid_q) rise_cyc <= cyc;
    valid_q <= valid;
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold(logic v, int n);
    uart_rx = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(logic [7:0] b, logic stop);
    start_cyc = cyc;
    hold(1'b0, BT);
    for (int i = 0; i < 8; i++) hold(b[i], BT);
    hold(stop, BT);
  endtask

  // Frame-level rules: good stop loads the byte, bad stop flags.
  task automatic model_frame(logic [7:0] b, logic stop,
                             logic ack_same);
    if (stop) begin
      if (m_valid && !ack_same) m_ov++;
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_fe++;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clock);
    #1;
    ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic check_state(string tag);
    check({tag, "_data"}, dataOut, m_data);
    check({tag, "_valid"}, valid, m_valid);
    check({tag, "_fe"}, fe_seen, m_fe);
    check({tag, "_ov"}, ov_seen, m_ov);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_data"}, dataOut, 8'h00);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_fe"}, frameError, 1'b0);
    check({tag, "_ov"}, overrun, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    reset_n = 1'b1;
    hold(1'b1, 5);

    send(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    lat = rise_cyc - start_cyc;
    check("lat_range", (lat >= 152 && lat <= 156), 1);
    check_state("a5");
    do_ack();
    check("ack_clr", valid, 1'b0);
    if (lat < 2 || lat > 200) lat = 155;

    hold(1'b0, 3);
    hold(1'b1, 30);
    check_state("glitch");
    send(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1, 1'b0);
    check_state("3c");
    do_ack();

    send(8'h55, 1'b0);
    model_frame(8'h55, 1'b0, 1'b0);
    hold(1'b0, 40);
    check_state("brk_low");
    hold(1'b1, 5);
    check_state("brk_high");
    send(8'h0F, 1'b1);
    model_frame(8'h0F, 1'b1, 1'b0);
    check_state("0f");
    do_ack();

    send(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1);
    model_frame(8'h22, 1'b1, 1'b0);
    check_state("b2b");

    fork
      send(8'h33, 1'b1);
      begin
        repeat (lat - 1) @(posedge clock);
        #1 ack = 1'b1;
        @(posedge clock);
        #1 ack = 1'b0;
      end
    join
    model_frame(8'h33, 1'b1, 1'b1);
    check_state("ack_same");

    fork
      send(8'hFF, 1'b1);
      begin
        repeat (BT * 5 + 8) @(posedge clock);
        #1 reset_n = 1'b0;
        #1 check_zero("mid_rst");
        m_data  = '0;
        m_valid = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
      end
    join
    hold(1'b1, 4);
    check_state("rst_after");
    send(8'h81, 1'b1);
    model_frame(8'h81, 1'b1, 1'b0);
    check_state("81");
    do_ack();

    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send(b, stop);
      model_frame(b, stop, 1'b0);
      check_state($sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) do_ack();
      if (stop) hold(1'b1, $urandom_range(0, 6));
      else      hold(1'b1, $urandom_range(3, 10));
    end

    hold(1'b1, 20);
    check_state("final");
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_receiver.md
Name: uart_rx_receiver

Overview:
- 8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Pairs with the team's UART transmitter and shares its CLOCK_SPEED/BAUD_RATE timing convention.
- Synchronises the asynchronous rx line, validates the start bit at mid-bit and samples each data bit at mid-bit.
- Presents each byte through a hold register with a valid/ack handshake, and reports framing errors and overruns.

Parameters:
- CLOCK_SPEED, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s. BIT_TICKS = CLOCK_SPEED/BAUD_RATE (integer divide, must be >= 4). HALF_TICKS = BIT_TICKS/2.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line, asynchronous, idle high.
- dataOut  output  8  last received byte.
- valid  output  1  high while dataOut holds an unacknowledged byte.
- ack  input  1  consumer read strobe; clears valid.
- frameError  output  1  one-cycle pulse when the stop bit samples 0.
- overrun  output  1  one-cycle pulse when a byte completes while valid=1 and ack=0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: dataOut=0, valid=0, frameError=0, overrun=0.
  - Internal: state=IDLE, synchroniser flops=1, tick counter=0, bit index=0.
  - Reset mid-frame abandons the frame. No output is produced for it.
- Synchroniser: two flops on uart_rx. All logic uses the second flop (rxs). Input-to-rxs latency is 2 cycles.
- Tick counter: 32-bit. Cleared on every state entry. Each state waits until the counter reaches its target, then samples rxs.
- IDLE:
  - rxs=0 -> START.
- START (target HALF_TICKS-1):
  - rxs=0 -> DATA, bit index=0.
  - rxs=1 -> IDLE. This is glitch rejection; no output.
- DATA (target BIT_TICKS-1 per bit):
  - Shift register[bit index] <= rxs, bit index += 1.
  - After bit 7 -> STOP.
- STOP (target BIT_TICKS-1):
  - rxs=1: dataOut <= shift register, valid <= 1, -> IDLE.
  - If valid was already 1 and ack=0 that cycle, pulse overrun. The new byte still overwrites dataOut and valid stays 1.
  - rxs=0: pulse frameError. dataOut and valid are unchanged. -> BREAK.
- BREAK: wait for rxs=1, then -> IDLE. A held-low line (break) produces exactly one frameError.
- ack:
  - When valid=1, clears valid next cycle.
  - ack with valid=0 is ignored.
  - ack in the same cycle a byte completes: the new byte loads, valid stays 1, no overrun.
- Sampling point: bit n is sampled (HALF_TICKS + (n+1)*BIT_TICKS) ± 1 cycles after the start edge reaches rxs.
- Back-to-back frames: a start edge is accepted from the first IDLE cycle after STOP. No inter-frame gap is required.
- frameError and overrun are never asserted outside a STOP sample cycle.

Test Plan:
- Setup: CLOCK_SPEED=16, BAUD_RATE=1, so BIT_TICKS=16 and HALF_TICKS=8.
- Byte 0xA5 at 16 cycles/bit -> valid rises 152..156 cycles after the start falling edge, dataOut=0xA5, frameError=0; ack one cycle -> valid=0 next cycle.
- Low glitch of 3 cycles on idle line -> no valid, no frameError; state returns to IDLE; a following 0x3C is received correctly.
- Frame 0x55 with stop bit driven 0, line held low 40 cycles -> exactly one frameError pulse; valid stays 0; dataOut unchanged; the next frame 0x0F is received after the line returns high.
- Two back-to-back frames 0x11, 0x22 with no ack -> one overrun pulse at the second stop sample; dataOut=0x22, valid=1.
- ack asserted on the exact cycle the second byte completes -> no overrun, valid=1, dataOut=second byte.
- reset_n pulsed low during data bit 4 of 0xFF -> all outputs 0 immediately; no valid for that frame; the subsequent 0x81 is received correctly.
